// File: rtl/mem_loader_if.sv
// Read-request bus between mem_loader (master) and a backing memory (slave).
// A request is accepted when mem_rd_en and mem_gnt are both high; mem_rdata follows one cycle later.
interface mem_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_gnt, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_gnt, output mem_rdata);
endinterface

// File: rtl/mem_loader.sv
// Streams filter and image words from memory into local buffers with combinational read ports.
// Optional feature: define MEM_LOADER_CHECKSUM_EN to add a per-load checksum output.
module mem_loader #(
  parameter int unsigned IMG_SIZE    = 16,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned FILTER_LEN  = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [1:0]                             mode,
  input  logic [ADDR_W-1:0]                      img_base,
  input  logic [ADDR_W-1:0]                      filt_base,
  mem_loader_if.master                           mem,
  input  logic [$clog2(IMG_SIZE*IMG_SIZE)-1:0]   img_rd_addr,
  output logic [DATA_W-1:0]                      img_rd_data,
  input  logic [$clog2(NUM_FILTERS)-1:0]         filt_rd_sel,
  input  logic [$clog2(FILTER_LEN)-1:0]          filt_rd_idx,
  output logic [DATA_W-1:0]                      filt_rd_data,
  output logic                                   busy,
  output logic                                   done
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W+15:0]                     checksum
`endif
);

  localparam int unsigned IMG_WORDS  = IMG_SIZE * IMG_SIZE;
  localparam int unsigned FILT_WORDS = NUM_FILTERS * FILTER_LEN;
  localparam int unsigned MAX_WORDS  = (IMG_WORDS > FILT_WORDS) ? IMG_WORDS : FILT_WORDS;
  localparam int unsigned CNT_W      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned IA_W       = $clog2(IMG_WORDS);
  localparam int unsigned FA_W       = $clog2(FILT_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD_FILT, LOAD_IMG, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  wr_idx;
  logic              wr_pend;
  logic              wr_img;
  logic              do_img;
  logic [ADDR_W-1:0] img_base_q;
  logic              accept_c;
  logic              start_c;
  logic [FA_W-1:0]   filt_ra_c;

  logic [DATA_W-1:0] img_mem  [IMG_WORDS];
  logic [DATA_W-1:0] filt_mem [FILT_WORDS];

  assign accept_c = mem.mem_rd_en & mem.mem_gnt;
  assign start_c  = start && ((state == IDLE) || (state == DONE));

  // Load sequencer: the counter and address advance only on accepted requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem.mem_rd_en <= 1'b0;
      mem.mem_addr  <= '0;
      cnt           <= '0;
      wr_idx        <= '0;
      wr_pend       <= 1'b0;
      wr_img        <= 1'b0;
      do_img        <= 1'b0;
      img_base_q    <= '0;
    end else begin
      wr_pend <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_c) begin
            busy          <= 1'b1;
            done          <= 1'b0;
            mem.mem_rd_en <= 1'b1;
            cnt           <= '0;
            img_base_q    <= img_base;
            do_img        <= (mode != 2'b10);
            if (mode == 2'b01) begin
              state        <= LOAD_IMG;
              mem.mem_addr <= img_base;
            end else begin
              state        <= LOAD_FILT;
              mem.mem_addr <= filt_base;
            end
          end
        end
        LOAD_FILT: begin
          if (accept_c) begin
            wr_pend <= 1'b1;
            wr_img  <= 1'b0;
            wr_idx  <= cnt;
            if (cnt == CNT_W'(FILT_WORDS - 1)) begin
              cnt <= '0;
              // Hand straight over to the image phase so the request port never idles.
              if (do_img) begin
                state        <= LOAD_IMG;
                mem.mem_addr <= img_base_q;
              end else begin
                state         <= DRAIN;
                mem.mem_rd_en <= 1'b0;
              end
            end else begin
              cnt          <= cnt + CNT_W'(1);
              mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
            end
          end
        end
        LOAD_IMG: begin
          if (accept_c) begin
            wr_pend <= 1'b1;
            wr_img  <= 1'b1;
            wr_idx  <= cnt;
            if (cnt == CNT_W'(IMG_WORDS - 1)) begin
              cnt           <= '0;
              state         <= DRAIN;
              mem.mem_rd_en <= 1'b0;
            end else begin
              cnt          <= cnt + CNT_W'(1);
              mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffers keep their contents through reset; a word returning right after reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_pend) begin
      if (wr_img) img_mem[wr_idx[IA_W-1:0]]  <= mem.mem_rdata;
      else        filt_mem[wr_idx[FA_W-1:0]] <= mem.mem_rdata;
    end
  end

  assign filt_ra_c    = FA_W'(filt_rd_sel) * FA_W'(FILTER_LEN) + FA_W'(filt_rd_idx);
  assign img_rd_data  = img_mem[img_rd_addr];
  assign filt_rd_data = filt_mem[filt_ra_c];

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam int unsigned CS_W = DATA_W + 16;

  // Running sum of every word committed to the buffers during the current load.
  always_ff @(posedge clk) begin
    if (!rst)         checksum <= '0;
    else if (start_c) checksum <= '0;
    else if (wr_pend) checksum <= checksum + CS_W'(mem.mem_rdata);
  end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: queue-based request/buffer model plus directed literal checks.
module tb_mem_loader;
  localparam int unsigned IMG_SIZE    = 16;
  localparam int unsigned NUM_FILTERS = 4;
  localparam int unsigned FILTER_LEN  = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned IMG_WORDS   = IMG_SIZE * IMG_SIZE;
  localparam int unsigned FILT_WORDS  = NUM_FILTERS * FILTER_LEN;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] img_base;
  logic [7:0] filt_base;
  logic [7:0] img_rd_addr;
  logic [7:0] img_rd_data;
  logic [1:0] filt_rd_sel;
  logic [3:0] filt_rd_idx;
  logic [7:0] filt_rd_data;
  logic       busy;
  logic       done;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [23:0] checksum;
`endif

  mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_loader #(
    .IMG_SIZE(IMG_SIZE), .NUM_FILTERS(NUM_FILTERS), .FILTER_LEN(FILTER_LEN),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .img_base(img_base),
    .filt_base(filt_base),
    .mem(mem_bus),
    .img_rd_addr(img_rd_addr),
    .img_rd_data(img_rd_data),
    .filt_rd_sel(filt_rd_sel),
    .filt_rd_idx(filt_rd_idx),
    .filt_rd_data(filt_rd_data),
    .busy(busy),
    .done(done)
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents, shared by the slave and the model.
  logic [7:0] mem_arr [256];
  task automatic set_pattern(input logic [7:0] x);
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a) ^ x;
  endtask

  // Memory slave: grant policy and one-cycle read latency.
  logic gnt_toggle;
  int   acc_count;
  initial begin
    logic       acc;
    logic [7:0] a;
    gnt_toggle = 1'b0;
    acc_count  = 0;
    mem_bus.mem_gnt   = 1'b1;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = mem_bus.mem_rd_en & mem_bus.mem_gnt;
      a   = mem_bus.mem_addr;
      if (acc) acc_count++;
      @(posedge clk);
      #1;
      mem_bus.mem_rdata = acc ? mem_arr[a] : 8'($urandom);
      mem_bus.mem_gnt   = gnt_toggle ? ~mem_bus.mem_gnt : 1'b1;
    end
  end

  // Behavioural model: an ordered list of expected requests and the buffer images they produce.
  logic       chk_en;
  bit         m_busy, m_done;
  int         head;
  int         q_addr[$];
  bit         q_img[$];
  int         q_idx[$];
  bit         pend, pend_img;
  int         pend_idx, pend_addr;
  logic [7:0] exp_img  [IMG_WORDS];
  bit         known_img [IMG_WORDS];
  logic [7:0] exp_filt [FILT_WORDS];
  bit         known_filt [FILT_WORDS];
  int         m_cks;
  int         done_rises;
  logic       prev_done;

  initial begin
    chk_en = 1'b0; m_busy = 0; m_done = 0; head = 0; pend = 0; m_cks = 0;
    done_rises = 0; prev_done = 1'b0;
    for (int i = 0; i < IMG_WORDS; i++) known_img[i] = 0;
    for (int i = 0; i < FILT_WORDS; i++) known_filt[i] = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("mem_rd_en", 32'(mem_bus.mem_rd_en), 32'(m_busy && head < q_addr.size()));
        if (m_busy && head < q_addr.size())
          chk("mem_addr", 32'(mem_bus.mem_addr), 32'(q_addr[head]));
`ifdef MEM_LOADER_CHECKSUM_EN
        if (m_done) chk("checksum", 32'(checksum), 32'(m_cks));
`endif
        if (done && !prev_done) done_rises++;
      end
      prev_done = done;
      // Predict the effect of the coming rising edge.
      if (!rst) begin
        m_busy = 0; m_done = 0; head = 0; pend = 0;
        q_addr.delete(); q_img.delete(); q_idx.delete();
      end else begin
        if (pend) begin
          if (pend_img) begin exp_img[pend_idx] = mem_arr[pend_addr]; known_img[pend_idx] = 1; end
          else begin exp_filt[pend_idx] = mem_arr[pend_addr]; known_filt[pend_idx] = 1; end
          m_cks += int'(mem_arr[pend_addr]);
          pend = 0;
        end
        if (!m_busy) begin
          if (start) begin
            q_addr.delete(); q_img.delete(); q_idx.delete();
            head = 0; m_cks = 0; m_busy = 1; m_done = 0;
            if (mode != 2'b01)
              for (int k = 0; k < FILT_WORDS; k++) begin
                q_addr.push_back((int'(filt_base) + k) % 256); q_img.push_back(0); q_idx.push_back(k);
              end
            if (mode != 2'b10)
              for (int p = 0; p < IMG_WORDS; p++) begin
                q_addr.push_back((int'(img_base) + p) % 256); q_img.push_back(1); q_idx.push_back(p);
              end
          end
        end else if (head < q_addr.size()) begin
          if (mem_bus.mem_gnt) begin
            pend = 1; pend_img = q_img[head]; pend_idx = q_idx[head]; pend_addr = q_addr[head];
            head++;
          end
        end else begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  // Pulse start for one sampling edge, then scramble the sampled inputs.
  task automatic start_load(input logic [1:0] m, input logic [7:0] fb, input logic [7:0] ib);
    @(posedge clk); #1;
    start = 1'b1; mode = m; filt_base = fb; img_base = ib;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; filt_base = 8'h55; img_base = 8'hAA;
  endtask

  // cyc = rising edges from the edge start was driven after, up to the one that raised done.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (cyc < 2000) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      cyc++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < IMG_WORDS; i++)
      if (known_img[i]) begin
        img_rd_addr = 8'(i); #1;
        chk({tag, "_img"}, 32'(img_rd_data), 32'(exp_img[i]));
      end
    for (int i = 0; i < FILT_WORDS; i++)
      if (known_filt[i]) begin
        filt_rd_sel = 2'(i / FILTER_LEN); filt_rd_idx = 4'(i % FILTER_LEN); #1;
        chk({tag, "_filt"}, 32'(filt_rd_data), 32'(exp_filt[i]));
      end
  endtask

  task automatic rd_img(input int a, output logic [7:0] d);
    img_rd_addr = 8'(a); #1; d = img_rd_data;
  endtask

  initial begin
    int         cyc;
    int         rises0;
    logic [7:0] d;
    rst = 1'b0; start = 1'b0; mode = 2'b00; img_base = '0; filt_base = '0;
    img_rd_addr = '0; filt_rd_sel = '0; filt_rd_idx = '0;
    set_pattern(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en", 32'(mem_bus.mem_rd_en), 32'd0);
    chk("reset_addr", 32'(mem_bus.mem_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Full load, continuous grant.
    start_load(2'b00, 8'h00, 8'h40);
    wait_done(cyc);
    chk("t1_latency", 32'(cyc), 32'd322);
    sweep("t1");
    filt_rd_sel = 2'd2; filt_rd_idx = 4'd5; #1;
    chk("t1_filt2_idx5", 32'(filt_rd_data), 32'h25);
    rd_img(0, d);   chk("t1_img0", 32'(d), 32'h40);
    rd_img(255, d); chk("t1_img255", 32'(d), 32'h3F);

    // Filters only, grant toggling every cycle, started directly from DONE.
    set_pattern(8'hA5);
    acc_count = 0;
    gnt_toggle = 1'b1;
    start_load(2'b10, 8'h00, 8'h40);
    wait_done(cyc);
    gnt_toggle = 1'b0;
    chk("t2_accepts", 32'(acc_count), 32'd64);
    sweep("t2");
    filt_rd_sel = 2'd3; filt_rd_idx = 4'd15; #1;
    chk("t2_filt3_idx15", 32'(filt_rd_data), 32'h3F ^ 32'hA5);
    rd_img(1, d); chk("t2_img1_kept", 32'(d), 32'h41);

    // Image only with address wrap.
    set_pattern(8'h00);
    start_load(2'b01, 8'h00, 8'hF0);
    wait_done(cyc);
    chk("t3_latency", 32'(cyc), 32'd258);
    sweep("t3");
    rd_img(0, d);   chk("t3_img0", 32'(d), 32'hF0);
    rd_img(16, d);  chk("t3_img16", 32'(d), 32'h00);
    rd_img(255, d); chk("t3_img255", 32'(d), 32'hEF);

    // Reset in the middle of a load, then a clean reload.
    start_load(2'b00, 8'h00, 8'h40);
    repeat (99) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_rd_en", 32'(mem_bus.mem_rd_en), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_addr", 32'(mem_bus.mem_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    start_load(2'b00, 8'h00, 8'h40);
    wait_done(cyc);
    chk("t4_latency", 32'(cyc), 32'd322);
    sweep("t4");

    // Mode 11 behaves as 00; a start pulse during the image phase is ignored.
    rises0 = done_rises;
    start_load(2'b11, 8'h00, 8'h40);
    repeat (100) @(posedge clk);
    start_load(2'b01, 8'h10, 8'h20);
    wait_done(cyc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_single_done", 32'(done_rises - rises0), 32'd1);
    sweep("t5");
    rd_img(0, d); chk("t5_img0", 32'(d), 32'h40);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("t5_checksum", 32'(checksum), 32'd34656);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
